decode_stage: RTL and testbench
===============================

# decode_stage

Pipelined, parametrised instruction-decode stage for the LEGv8 datapath, sitting between fetch and execute. It owns the architectural register file, decodes R/D/CB/B formats into control bits and a sign-extended immediate, and registers everything into an ID/EX pipeline register. It adds what the single-cycle decoder lacked: a valid/ready handshake on both sides, same-cycle writeback bypass, one-bubble load-use stall, flush, and illegal-opcode flagging.

## Interface
- WORD, 64: datapath and register width.
- ZERO_REG, 1: when 1, X31 reads as zero and writes to X31 are dropped.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  fetch presents instr/pc.
- in_ready  out  1  stage accepts this cycle (combinational).
- instr  in  32  instruction word.
- pc  in  WORD  instruction address.
- wb_en  in  1  writeback strobe.
- wb_reg  in  5  writeback register.
- wb_data  in  WORD  writeback value.
- flush  in  1  kill the in-flight decode and the ID/EX contents.
- out_valid  out  1  ID/EX register holds a live instruction.
- out_ready  in  1  execute accepts.
- out_pc, out_read_data1, out_read_data2, out_ext_imm  out  WORD each.
- out_rn, out_rm, out_rd  out  5 each  register numbers (used by forwarding).
- out_alu_con_instr  out  11  instr[31:21].
- out_alu_op  out  2  00 memory, 01 branch, 10 R-type.
- out_uncondbranch, out_branch, out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write, out_illegal  out  1 each.

## Operation
- Decode on instr[31:21]: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 (R: alu_op 10, reg_write); LDUR 11111000010 (alu_src, mem_read, mem_to_reg, reg_write, alu_op 00); STUR 11111000000 (alu_src, mem_write, reg2 from rd, alu_op 00); CBZ 10110100xxx (branch, reg2 from rd, alu_op 01); B 000101xxxxx (uncondbranch).
- Any other opcode: out_illegal=1, all other control bits 0.
- Immediate: D-type sign-extend instr[20:12]; CB sign-extend instr[23:5]; B sign-extend instr[25:0]; R-type 0.
- Read port 2 selects rd for STUR/CBZ, otherwise rm.
- Register file: 32 x WORD, written on rising edge when wb_en. Reads are combinational with bypass: wb_en and wb_reg equal to the read index returns wb_data in the same cycle. With ZERO_REG, index 31 always reads 0 and the bypass does not apply to it.
- Load-use hazard: the ID/EX register holds a valid mem_read instruction whose out_rd (not 31) equals rn, or equals the selected reg2 for R-type, STUR or CBZ. The comparison ignores whether the current opcode is legal.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Register update:
  - accept (in_valid && in_ready): load all outputs, out_valid=1.
  - else if out_ready (including during a hazard): out_valid=0. This inserts the bubble.
  - else hold all outputs.
- flush: out_valid<=0 next edge; in_ready=0, so fetch holds the instruction. Flush overrides everything except reset.

## Timing
- Reset: out_valid and every out_* register read 0; the register file is cleared to 0; in_ready=1 once rst_n is high.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle when there is no hazard and out_ready=1.
- Load-use: costs exactly one bubble cycle. The dependent instruction is accepted the cycle after the load leaves ID/EX.
- Backpressure: while out_valid && !out_ready, all outputs are stable and in_ready=0.
- Writeback on the same edge as accept: the accepted operands reflect wb_data through the bypass.
- Reset asserted mid-stream: outputs clear immediately (asynchronous); any pending instruction is lost.

## Test plan
- Reset, then present ADD X3,X1,X2 with X1=5 and X2=7 preloaded via wb -> next cycle out_valid=1, read_data1=5, read_data2=7, alu_op=10, reg_write=1.
- LDUR X1,[X2,#-8] -> ext_imm=0xFFFF_FFFF_FFFF_FFF8, mem_read=1, alu_src=1, mem_to_reg=1.
- LDUR X4 accepted, then ADD X5,X4,X6 with out_ready=1 -> in_ready=0 for one cycle, a bubble (out_valid=0), then ADD is accepted.
- wb_en with wb_reg=9 and wb_data=0xABCD, in the same cycle as CBZ X9 -> out_read_data2=0xABCD, branch=1, ext_imm = sign-extended instr[23:5].
- out_ready=0 for 3 cycles with in_valid=1 -> outputs frozen, in_ready=0. Then flush -> out_valid=0 next cycle.
- Opcode 0x7FF -> out_illegal=1, reg_write=0, mem_write=0. A wb to X31 followed by a read of X31 -> 0.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch-side, writeback and ID/EX signals of the LEGv8 decode stage.
// The stage itself connects through the slave modport.
interface decode_stage_if #(parameter int WORD = 64);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instr;
   logic [WORD-1:0] pc;
   logic            wb_en;
   logic [4:0]      wb_reg;
   logic [WORD-1:0] wb_data;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [WORD-1:0] out_pc;
   logic [WORD-1:0] out_read_data1;
   logic [WORD-1:0] out_read_data2;
   logic [WORD-1:0] out_ext_imm;
   logic [4:0]      out_rn;
   logic [4:0]      out_rm;
   logic [4:0]      out_rd;
   logic [10:0]     out_alu_con_instr;
   logic [1:0]      out_alu_op;
   logic            out_uncondbranch;
   logic            out_branch;
   logic            out_mem_read;
   logic            out_mem_to_reg;
   logic            out_mem_write;
   logic            out_alu_src;
   logic            out_reg_write;
   logic            out_illegal;

   modport slave (
      input  in_valid, instr, pc, wb_en, wb_reg, wb_data, flush, out_ready,
      output in_ready, out_valid, out_pc, out_read_data1, out_read_data2, out_ext_imm,
             out_rn, out_rm, out_rd, out_alu_con_instr, out_alu_op, out_uncondbranch,
             out_branch, out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src,
             out_reg_write, out_illegal
   );

   modport master (
      output in_valid, instr, pc, wb_en, wb_reg, wb_data, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_read_data1, out_read_data2, out_ext_imm,
             out_rn, out_rm, out_rd, out_alu_con_instr, out_alu_op, out_uncondbranch,
             out_branch, out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src,
             out_reg_write, out_illegal
   );
endinterface

// File: rtl/decode_stage.sv
// LEGv8 instruction decode stage: register file with writeback bypass, R/D/CB/B
// decode, load-use stall, flush and a valid/ready ID/EX pipeline register.
module decode_stage #(
   parameter int WORD     = 64,
   parameter bit ZERO_REG = 1'b1
) (
   input logic           clk,
   input logic           rst_n,
   decode_stage_if.slave bus
);
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;

   logic [WORD-1:0] rf [32];
   logic [10:0]     opc;
   logic [4:0]      rn, rm, rd, reg2;
   logic [1:0]      alu_op;
   logic            uncond, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
   logic            illegal, use_rd, is_r;
   logic [WORD-1:0] ext_imm, rd1, rd2;
   logic            hazard, accept;

   assign opc  = bus.instr[31:21];
   assign rn   = bus.instr[9:5];
   assign rm   = bus.instr[20:16];
   assign rd   = bus.instr[4:0];
   assign reg2 = use_rd ? rd : rm;

   always_comb begin
      alu_op     = 2'b00;
      uncond     = 1'b0;
      branch     = 1'b0;
      mem_read   = 1'b0;
      mem_to_reg = 1'b0;
      mem_write  = 1'b0;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      use_rd     = 1'b0;
      is_r       = 1'b0;
      ext_imm    = '0;
      casez (opc)
         OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
            is_r      = 1'b1;
            alu_op    = 2'b10;
            reg_write = 1'b1;
         end
         OP_LDUR: begin
            alu_src    = 1'b1;
            mem_read   = 1'b1;
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            ext_imm    = {{(WORD-9){bus.instr[20]}}, bus.instr[20:12]};
         end
         OP_STUR: begin
            alu_src   = 1'b1;
            mem_write = 1'b1;
            use_rd    = 1'b1;
            ext_imm   = {{(WORD-9){bus.instr[20]}}, bus.instr[20:12]};
         end
         11'b10110100???: begin
            branch  = 1'b1;
            use_rd  = 1'b1;
            alu_op  = 2'b01;
            ext_imm = {{(WORD-19){bus.instr[23]}}, bus.instr[23:5]};
         end
         11'b000101?????: begin
            uncond  = 1'b1;
            ext_imm = {{(WORD-26){bus.instr[25]}}, bus.instr[25:0]};
         end
         default: illegal = 1'b1;
      endcase
   end

   // Bypass first, then the zero register overrides it.
   always_comb begin
      rd1 = rf[rn];
      rd2 = rf[reg2];
      if (bus.wb_en && bus.wb_reg == rn)   rd1 = bus.wb_data;
      if (bus.wb_en && bus.wb_reg == reg2) rd2 = bus.wb_data;
      if (ZERO_REG && rn == 5'd31)         rd1 = '0;
      if (ZERO_REG && reg2 == 5'd31)       rd2 = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (bus.wb_en && !(ZERO_REG && bus.wb_reg == 5'd31)) begin
         rf[bus.wb_reg] <= bus.wb_data;
      end
   end

   assign hazard = bus.out_valid && bus.out_mem_read && bus.out_rd != 5'd31 &&
                   (bus.out_rd == rn || ((is_r || use_rd) && bus.out_rd == reg2));
   assign bus.in_ready = !bus.flush && !hazard && (!bus.out_valid || bus.out_ready);
   assign accept = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid         <= 1'b0;
         bus.out_pc            <= '0;
         bus.out_read_data1    <= '0;
         bus.out_read_data2    <= '0;
         bus.out_ext_imm       <= '0;
         bus.out_rn            <= '0;
         bus.out_rm            <= '0;
         bus.out_rd            <= '0;
         bus.out_alu_con_instr <= '0;
         bus.out_alu_op        <= '0;
         bus.out_uncondbranch  <= 1'b0;
         bus.out_branch        <= 1'b0;
         bus.out_mem_read      <= 1'b0;
         bus.out_mem_to_reg    <= 1'b0;
         bus.out_mem_write     <= 1'b0;
         bus.out_alu_src       <= 1'b0;
         bus.out_reg_write     <= 1'b0;
         bus.out_illegal       <= 1'b0;
      end else if (bus.flush) begin
         bus.out_valid <= 1'b0;
      end else if (accept) begin
         bus.out_valid         <= 1'b1;
         bus.out_pc            <= bus.pc;
         bus.out_read_data1    <= rd1;
         bus.out_read_data2    <= rd2;
         bus.out_ext_imm       <= ext_imm;
         bus.out_rn            <= rn;
         bus.out_rm            <= rm;
         bus.out_rd            <= rd;
         bus.out_alu_con_instr <= opc;
         bus.out_alu_op        <= alu_op;
         bus.out_uncondbranch  <= uncond;
         bus.out_branch        <= branch;
         bus.out_mem_read      <= mem_read;
         bus.out_mem_to_reg    <= mem_to_reg;
         bus.out_mem_write     <= mem_write;
         bus.out_alu_src       <= alu_src;
         bus.out_reg_write     <= reg_write;
         bus.out_illegal       <= illegal;
      end else if (bus.out_ready) begin
         // Nothing accepted while execute drains: this is the bubble.
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a reference decoder and shadow register file
// predict each ID/EX entry, which is compared when execute consumes it.
module tb_decode_stage;
   typedef struct packed {
      logic [63:0] pc, rd1, rd2, imm;
      logic [4:0]  rn, rm, rd;
      logic [10:0] con;
      logic [1:0]  alu_op;
      logic        ub, br, mr, m2r, mw, as, rw, ill;
   } exp_t;

   localparam logic [10:0] ADD  = 11'b10001011000;
   localparam logic [10:0] SUB  = 11'b11001011000;
   localparam logic [10:0] ANDI = 11'b10001010000;
   localparam logic [10:0] ORR  = 11'b10101010000;
   localparam logic [10:0] LDUR = 11'b11111000010;
   localparam logic [10:0] STUR = 11'b11111000000;

   logic        clk = 1'b0;
   logic        rst_n;
   int          total = 0;
   int          bad = 0;
   logic [63:0] shadow [32];
   exp_t        q [$];
   exp_t        last_exp;

   decode_stage_if #(.WORD(64)) bus ();
   decode_stage #(.WORD(64), .ZERO_REG(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   always #5 clk = ~clk;

   function automatic logic [31:0] r_i(logic [10:0] o, logic [4:0] m, logic [4:0] n, logic [4:0] d);
      return {o, m, 6'd0, n, d};
   endfunction
   function automatic logic [31:0] d_i(logic [10:0] o, logic [8:0] imm, logic [4:0] n, logic [4:0] t);
      return {o, imm, 2'b00, n, t};
   endfunction
   function automatic logic [31:0] cb_i(logic [18:0] imm, logic [4:0] t);
      return {8'hB4, imm, t};
   endfunction
   function automatic logic [31:0] b_i(logic [25:0] imm);
      return {6'b000101, imm};
   endfunction

   function automatic logic [63:0] sread(logic [4:0] idx);
      if (idx == 5'd31) return 64'd0;
      if (bus.wb_en && bus.wb_reg == idx) return bus.wb_data;
      return shadow[idx];
   endfunction

   function automatic exp_t model(logic [31:0] i, logic [63:0] p);
      exp_t       e;
      logic [4:0] r2;
      logic [10:0] o;
      o = i[31:21];
      e = '0;
      e.pc = p; e.rn = i[9:5]; e.rm = i[20:16]; e.rd = i[4:0]; e.con = o;
      r2 = i[20:16];
      if (o == ADD || o == SUB || o == ANDI || o == ORR) begin
         e.alu_op = 2'b10; e.rw = 1'b1;
      end else if (o == LDUR) begin
         e.as = 1'b1; e.mr = 1'b1; e.m2r = 1'b1; e.rw = 1'b1;
         e.imm = {{55{i[20]}}, i[20:12]};
      end else if (o == STUR) begin
         e.as = 1'b1; e.mw = 1'b1; r2 = i[4:0];
         e.imm = {{55{i[20]}}, i[20:12]};
      end else if (o[10:3] == 8'hB4) begin
         e.br = 1'b1; e.alu_op = 2'b01; r2 = i[4:0];
         e.imm = {{45{i[23]}}, i[23:5]};
      end else if (o[10:5] == 6'b000101) begin
         e.ub = 1'b1;
         e.imm = {{38{i[25]}}, i[25:0]};
      end else begin
         e.ill = 1'b1;
      end
      e.rd1 = sread(i[9:5]);
      e.rd2 = sread(r2);
      return e;
   endfunction

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      if (bus.wb_en && bus.wb_reg != 5'd31) shadow[bus.wb_reg] = bus.wb_data;
      @(posedge clk);
      #1;
   endtask

   task automatic present(logic [31:0] i, logic [63:0] p, logic exp_ready, string tag);
      bus.in_valid = 1'b1;
      bus.instr    = i;
      bus.pc       = p;
      #1;
      chk(tag, {63'd0, bus.in_ready}, {63'd0, exp_ready});
      if (exp_ready) begin
         last_exp = model(i, p);
         q.push_back(last_exp);
      end
   endtask

   // Scoreboard: an entry is consumed whenever execute takes a valid ID/EX word.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         exp_t o, e;
         o = '{bus.out_pc, bus.out_read_data1, bus.out_read_data2, bus.out_ext_imm,
               bus.out_rn, bus.out_rm, bus.out_rd, bus.out_alu_con_instr, bus.out_alu_op,
               bus.out_uncondbranch, bus.out_branch, bus.out_mem_read, bus.out_mem_to_reg,
               bus.out_mem_write, bus.out_alu_src, bus.out_reg_write, bus.out_illegal};
         total++;
         if (q.size() == 0) begin
            bad++;
            $error("FAIL sb_unexpected got=%h exp=none", o);
         end else begin
            e = q.pop_front();
            assert (o === e) else begin
               bad++;
               $error("FAIL sb_item got=%h exp=%h", o, e);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) shadow[i] = 64'd0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.instr = '0; bus.pc = '0;
      bus.wb_en = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
      bus.flush = 1'b0; bus.out_ready = 1'b1;
      #12;
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_out_pc", bus.out_pc, 64'd0);
      chk("rst_out_rd1", bus.out_read_data1, 64'd0);
      chk("rst_out_reg_write", {63'd0, bus.out_reg_write}, 64'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk); #1;

      // Preload X1=5, X2=7
      bus.wb_en = 1'b1; bus.wb_reg = 5'd1; bus.wb_data = 64'd5; tick();
      bus.wb_reg = 5'd2; bus.wb_data = 64'd7; tick();
      bus.wb_en = 1'b0;

      present(r_i(ADD, 5'd2, 5'd1, 5'd3), 64'h100, 1'b1, "add_ready");
      tick();
      chk("add_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("add_rd1", bus.out_read_data1, 64'd5);
      chk("add_rd2", bus.out_read_data2, 64'd7);
      chk("add_alu_op", {62'd0, bus.out_alu_op}, 64'd2);

      present(d_i(LDUR, 9'h1F8, 5'd2, 5'd1), 64'h104, 1'b1, "ldur_ready");
      tick();
      chk("ldur_imm", bus.out_ext_imm, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("ldur_mem_read", {63'd0, bus.out_mem_read}, 64'd1);

      // Load-use through rn
      present(d_i(LDUR, 9'h000, 5'd2, 5'd4), 64'h108, 1'b1, "ldur4_ready");
      tick();
      present(r_i(ADD, 5'd6, 5'd4, 5'd5), 64'h10C, 1'b0, "hazard_rn_stall");
      tick();
      chk("hazard_rn_bubble", {63'd0, bus.out_valid}, 64'd0);
      present(r_i(ADD, 5'd6, 5'd4, 5'd5), 64'h10C, 1'b1, "hazard_rn_release");
      tick();

      // Load-use through STUR data register
      present(d_i(LDUR, 9'h010, 5'd2, 5'd7), 64'h110, 1'b1, "ldur7_ready");
      tick();
      present(d_i(STUR, 9'h000, 5'd2, 5'd7), 64'h114, 1'b0, "hazard_rd_stall");
      tick();
      chk("hazard_rd_bubble", {63'd0, bus.out_valid}, 64'd0);
      present(d_i(STUR, 9'h000, 5'd2, 5'd7), 64'h114, 1'b1, "hazard_rd_release");
      tick();

      // CBZ with same-cycle writeback bypass
      bus.wb_en = 1'b1; bus.wb_reg = 5'd9; bus.wb_data = 64'hABCD;
      present(cb_i(19'h7FFF0, 5'd9), 64'h118, 1'b1, "cbz_ready");
      tick();
      bus.wb_en = 1'b0;
      chk("cbz_bypass", bus.out_read_data2, 64'hABCD);
      chk("cbz_imm", bus.out_ext_imm, 64'hFFFF_FFFF_FFFF_FFF0);
      chk("cbz_branch", {63'd0, bus.out_branch}, 64'd1);

      present(b_i(26'h0000123), 64'h11C, 1'b1, "b_ready");
      tick();

      // Backpressure for three cycles, then flush
      bus.out_ready = 1'b0;
      present(r_i(ANDI, 5'd2, 5'd1, 5'd10), 64'h120, 1'b0, "bp_ready");
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
         chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
         chk("bp_out_pc", bus.out_pc, last_exp.pc);
         chk("bp_out_imm", bus.out_ext_imm, last_exp.imm);
      end
      bus.flush = 1'b1;
      #1;
      chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd0);
      tick();
      chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
      void'(q.pop_front());
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      present(r_i(ANDI, 5'd2, 5'd1, 5'd10), 64'h120, 1'b1, "after_flush_ready");
      tick();

      present({11'h7FF, 21'h0}, 64'h124, 1'b1, "illegal_ready");
      tick();
      chk("illegal_flag", {63'd0, bus.out_illegal}, 64'd1);
      chk("illegal_reg_write", {63'd0, bus.out_reg_write}, 64'd0);
      chk("illegal_mem_write", {63'd0, bus.out_mem_write}, 64'd0);

      // Writes to X31 are dropped and never bypassed
      bus.in_valid = 1'b0;
      bus.wb_en = 1'b1; bus.wb_reg = 5'd31; bus.wb_data = 64'h1234;
      tick();
      bus.wb_data = 64'h5555;
      present(r_i(ADD, 5'd31, 5'd31, 5'd8), 64'h128, 1'b1, "x31_ready");
      tick();
      bus.wb_en = 1'b0;
      chk("x31_rd1", bus.out_read_data1, 64'd0);
      chk("x31_rd2", bus.out_read_data2, 64'd0);

      // Load into X31 never stalls
      present(d_i(LDUR, 9'h000, 5'd2, 5'd31), 64'h12C, 1'b1, "ldur31_ready");
      tick();
      present(r_i(ADD, 5'd1, 5'd31, 5'd9), 64'h130, 1'b1, "no_hazard_x31");
      tick();

      // Reset mid-stream clears outputs and the register file
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("midrst_out_pc", bus.out_pc, 64'd0);
      q.delete();
      for (int i = 0; i < 32; i++) shadow[i] = 64'd0;
      rst_n = 1'b1;
      present(r_i(ADD, 5'd2, 5'd1, 5'd3), 64'h200, 1'b1, "post_rst_ready");
      tick();
      chk("post_rst_rd1", bus.out_read_data1, 64'd0);
      bus.in_valid = 1'b0;
      tick();
      tick();
      chk("sb_drained", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
